// File: rtl/mxint_fifo_if.sv
// Bundles the MXINT block stream into and out of the FIFO, plus its occupancy status.
// master drives blocks in and accepts them out; slave is the FIFO side.
interface mxint_fifo_if #(
    parameter int DATA_PRECISION_0 = 8,
    parameter int DATA_PRECISION_1 = 8,
    parameter int IN_NUM           = 6,
    parameter int DEPTH            = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_PRECISION_0-1:0] mdata_in  [IN_NUM];
    logic [DATA_PRECISION_1-1:0] edata_in;
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic [DATA_PRECISION_0-1:0] mdata_out [IN_NUM];
    logic [DATA_PRECISION_1-1:0] edata_out;
    logic                        data_out_valid;
    logic                        data_out_ready;
    logic [CNT_W-1:0]            count;
    logic                        almost_full;

    modport master (
        output mdata_in, edata_in, data_in_valid, data_out_ready,
        input  data_in_ready, mdata_out, edata_out, data_out_valid, count, almost_full
    );

    modport slave (
        input  mdata_in, edata_in, data_in_valid, data_out_ready,
        output data_in_ready, mdata_out, edata_out, data_out_valid, count, almost_full
    );
endinterface

// File: rtl/mxint_fifo.sv
// First-word-fall-through FIFO of MXINT blocks (IN_NUM mantissas + shared exponent); 1-cycle latency.
// Ready/valid depend only on registered occupancy: ready low when full, valid low when empty.
module mxint_fifo #(
    parameter int DATA_PRECISION_0  = 8,
    parameter int DATA_PRECISION_1  = 8,
    parameter int IN_NUM            = 6,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input logic         clk,
    input logic         rst,
    mxint_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_PRECISION_0-1:0] mant_mem [DEPTH][IN_NUM];
    logic [DATA_PRECISION_1-1:0] exp_mem  [DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;
    logic                        push;
    logic                        pop;

    assign bus.data_in_ready  = (count != CNT_W'(DEPTH));
    assign bus.data_out_valid = (count != '0);
    assign bus.count          = count;
    assign bus.almost_full    = (count >= CNT_W'(ALMOST_FULL_LEVEL));

    assign push = bus.data_in_valid  && bus.data_in_ready;
    assign pop  = bus.data_out_valid && bus.data_out_ready;

    // Head is read straight out of storage, so a push into an empty FIFO shows up after the edge.
    assign bus.edata_out = exp_mem[rd_ptr];
    for (genvar i = 0; i < IN_NUM; i++) begin : g_out
        assign bus.mdata_out[i] = mant_mem[rd_ptr][i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                exp_mem[d] <= '0;
                for (int i = 0; i < IN_NUM; i++) begin
                    mant_mem[d][i] <= '0;
                end
            end
        end else if (push) begin
            exp_mem[wr_ptr] <= bus.edata_in;
            for (int i = 0; i < IN_NUM; i++) begin
                mant_mem[wr_ptr][i] <= bus.mdata_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mxint_fifo.sv
// Scoreboard bench for mxint_fifo: default configuration (DUT A) and DEPTH=3 narrow-mantissa (DUT B).
module tb_mxint_fifo;
    localparam int AW0 = 8, AW1 = 8, AN = 6, AD = 4;
    localparam int BW0 = 4, BW1 = 8, BN = 6, BD = 3;
    localparam int AE  = AN * AW0 + AW1;
    localparam int BE  = BN * BW0 + BW1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [AE-1:0] qa[$];
    logic [BE-1:0] qb[$];

    always #5 clk = ~clk;

    mxint_fifo_if #(.DATA_PRECISION_0(AW0), .DATA_PRECISION_1(AW1), .IN_NUM(AN), .DEPTH(AD)) ia();
    mxint_fifo_if #(.DATA_PRECISION_0(BW0), .DATA_PRECISION_1(BW1), .IN_NUM(BN), .DEPTH(BD)) ib();

    mxint_fifo #(.DATA_PRECISION_0(AW0), .DATA_PRECISION_1(AW1), .IN_NUM(AN), .DEPTH(AD))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mxint_fifo #(.DATA_PRECISION_0(BW0), .DATA_PRECISION_1(BW1), .IN_NUM(BN), .DEPTH(BD))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    function automatic logic [AE-1:0] pack_in_a();
        logic [AE-1:0] v;
        v[AW1-1:0] = ia.edata_in;
        for (int i = 0; i < AN; i++) v[AW1 + AW0*i +: AW0] = ia.mdata_in[i];
        return v;
    endfunction

    function automatic logic [AE-1:0] pack_out_a();
        logic [AE-1:0] v;
        v[AW1-1:0] = ia.edata_out;
        for (int i = 0; i < AN; i++) v[AW1 + AW0*i +: AW0] = ia.mdata_out[i];
        return v;
    endfunction

    function automatic logic [BE-1:0] pack_in_b();
        logic [BE-1:0] v;
        v[BW1-1:0] = ib.edata_in;
        for (int i = 0; i < BN; i++) v[BW1 + BW0*i +: BW0] = ib.mdata_in[i];
        return v;
    endfunction

    function automatic logic [BE-1:0] pack_out_b();
        logic [BE-1:0] v;
        v[BW1-1:0] = ib.edata_out;
        for (int i = 0; i < BN; i++) v[BW1 + BW0*i +: BW0] = ib.mdata_out[i];
        return v;
    endfunction

    task automatic drive_a(input logic vld, input logic rdy, input logic [AW1-1:0] e);
        ia.data_in_valid  = vld;
        ia.data_out_ready = rdy;
        ia.edata_in       = e;
        for (int i = 0; i < AN; i++) ia.mdata_in[i] = AW0'($urandom);
    endtask

    task automatic drive_b(input logic vld, input logic rdy);
        ib.data_in_valid  = vld;
        ib.data_out_ready = rdy;
        ib.edata_in       = BW1'($urandom);
        for (int i = 0; i < BN; i++) ib.mdata_in[i] = BW0'($urandom);
    endtask

    // Called at a falling edge with inputs already driven; commits the handshakes of the next rising edge.
    task automatic step_a();
        logic          push, pop;
        logic [AE-1:0] exp_v;
        push = ia.data_in_valid && ia.data_in_ready;
        pop  = ia.data_out_valid && ia.data_out_ready;
        total++;
        if (ia.count !== 3'(qa.size()))
            begin bad++; $display("FAIL a_count got=%0d want=%0d", ia.count, qa.size()); end
        total++;
        if (ia.data_out_valid !== (qa.size() != 0))
            begin bad++; $display("FAIL a_valid got=%b want=%b", ia.data_out_valid, qa.size() != 0); end
        total++;
        if (ia.data_in_ready !== (qa.size() != AD))
            begin bad++; $display("FAIL a_ready got=%b want=%b", ia.data_in_ready, qa.size() != AD); end
        total++;
        if (ia.almost_full !== (qa.size() >= AD - 1))
            begin bad++; $display("FAIL a_almost_full got=%b want=%b", ia.almost_full, qa.size() >= AD - 1); end
        if (pop) begin
            exp_v = qa.pop_front();
            total++;
            if (pack_out_a() !== exp_v)
                begin bad++; $display("FAIL a_data got=%h want=%h", pack_out_a(), exp_v); end
        end
        if (push) qa.push_back(pack_in_a());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b();
        logic          push, pop;
        logic [BE-1:0] exp_v;
        push = ib.data_in_valid && ib.data_in_ready;
        pop  = ib.data_out_valid && ib.data_out_ready;
        total++;
        if (ib.count !== 2'(qb.size()) || ib.count > 2'd3 || ib.data_out_valid !== (qb.size() != 0))
            begin bad++; $display("FAIL b_state count=%0d valid=%b want_count=%0d", ib.count, ib.data_out_valid, qb.size()); end
        if (pop) begin
            exp_v = qb.pop_front();
            total++;
            if (pack_out_b() !== exp_v)
                begin bad++; $display("FAIL b_data got=%h want=%h", pack_out_b(), exp_v); end
        end
        if (push) qb.push_back(pack_in_b());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_a();
        drive_a(1'b0, 1'b1, '0);
        for (int c = 0; c < 20 && qa.size() != 0; c++) step_a();
        total++;
        if (qa.size() != 0 || ia.data_out_valid !== 1'b0)
            begin bad++; $display("FAIL a_drain left=%0d valid=%b want=0", qa.size(), ia.data_out_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        total++;
        if (ia.data_out_valid !== 1'b0 || ia.data_in_ready !== 1'b1 || ia.count !== '0 || ia.almost_full !== 1'b0)
            begin bad++; $display("FAIL reset_ctrl valid=%b ready=%b count=%0d af=%b want 0 1 0 0",
                                  ia.data_out_valid, ia.data_in_ready, ia.count, ia.almost_full); end
        total++;
        if (pack_out_a() !== '0)
            begin bad++; $display("FAIL reset_data got=%h want=0", pack_out_a()); end
        total++;
        if (ib.data_out_valid !== 1'b0 || ib.data_in_ready !== 1'b1 || pack_out_b() !== '0)
            begin bad++; $display("FAIL reset_b valid=%b ready=%b data=%h want 0 1 0",
                                  ib.data_out_valid, ib.data_in_ready, pack_out_b()); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic [AE-1:0] head;
        for (int i = 1; i <= AD; i++) begin
            drive_a(1'b1, 1'b0, AW1'(i));
            step_a();
        end
        total++;
        if (ia.count !== 3'd4 || ia.data_in_ready !== 1'b0 || ia.almost_full !== 1'b1)
            begin bad++; $display("FAIL fill_full count=%0d ready=%b af=%b want 4 0 1",
                                  ia.count, ia.data_in_ready, ia.almost_full); end
        total++;
        if (ia.edata_out !== 8'd1)
            begin bad++; $display("FAIL fill_head got=%0d want=1", ia.edata_out); end
        head = qa[0];
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, 8'hAA);
            step_a();
        end
        total++;
        if (pack_out_a() !== head || qa.size() != AD)
            begin bad++; $display("FAIL fill_hold got=%h want=%h", pack_out_a(), head); end
    endtask

    task automatic test_drain_wrap();
        int n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            drive_a(1'b1, 1'b1, AW1'($urandom));
            if (ia.data_in_ready) n++;
            step_a();
        end
        total++;
        if (n != 10)
            begin bad++; $display("FAIL wrap_pushes got=%0d want=10", n); end
        drain_a();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 1'b0, AW1'(8'h20 + i));
            step_a();
        end
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, 1'b1, AW1'(8'h30 + i));
            step_a();
            total++;
            if (ia.count !== 3'd2)
                begin bad++; $display("FAIL b2b_count got=%0d want=2", ia.count); end
        end
        drain_a();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, AW1'(8'h40 + i));
            step_a();
        end
        total++;
        if (ia.count !== 3'd3)
            begin bad++; $display("FAIL mid_pre count got=%0d want=3", ia.count); end
        drive_a(1'b0, 1'b0, '0);
        #2 rst = 1'b0;
        #1;
        total++;
        if (ia.data_out_valid !== 1'b0 || ia.count !== '0 || ia.data_in_ready !== 1'b1)
            begin bad++; $display("FAIL mid_async valid=%b count=%0d ready=%b want 0 0 1",
                                  ia.data_out_valid, ia.count, ia.data_in_ready); end
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b1, 1'b0, 8'h7F);
        step_a();
        total++;
        if (ia.data_out_valid !== 1'b1 || ia.edata_out !== 8'h7F)
            begin bad++; $display("FAIL mid_head valid=%b edata=%h want 1 7f", ia.data_out_valid, ia.edata_out); end
        drain_a();
    endtask

    task automatic test_random_depth3();
        for (int c = 0; c < 1000; c++) begin
            drive_b(1'($urandom), 1'($urandom));
            step_b();
        end
        drive_b(1'b0, 1'b1);
        for (int c = 0; c < 10 && qb.size() != 0; c++) step_b();
        total++;
        if (qb.size() != 0 || ib.data_out_valid !== 1'b0)
            begin bad++; $display("FAIL b_drain left=%0d valid=%b want=0", qb.size(), ib.data_out_valid); end
    endtask

    initial begin
        drive_a(1'b0, 1'b0, '0);
        drive_b(1'b0, 1'b0);
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random_depth3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
